ex_mem_pipe_stage: RTL
======================

// Module: ex_mem_pipe_stage
// PURPOSE
//  Parametrised EX->MEM pipeline register with valid/ready handshake, stall and flush.
//  Carries instruction, ALU result, write-enable and register-write address through STAGES register slots.
//  Sits between the execute ALU and the memory stage; replaces fixed single-stage pipeline registers.
//  Supports backpressure from MEM and squash from the branch/hazard unit.
// PARAMETERS
//  INST_W   16  instruction width
//  DATA_W   16  result width
//  ADDR_W   3   register-file write-address width
//  STAGES   1   number of chained register slots; must be >=1 (elaboration error otherwise)
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       asynchronous, active-low reset
//  flush          in   1       synchronous squash of all in-flight beats
//  in_valid       in   1       upstream beat valid
//  in_ready       out  1       stage can accept a beat
//  in_inst        in   INST_W  instruction
//  in_res         in   DATA_W  ALU result
//  in_wr_en       in   1       register-file write enable
//  in_write_addr  in   ADDR_W  register-file write address
//  out_valid      out  1       downstream beat valid
//  out_ready      in   1       MEM stage accepts beat
//  out_inst       out  INST_W  instruction
//  out_res        out  DATA_W  result
//  out_wr_en      out  1       write enable, gated: stored wr_en AND out_valid
//  out_write_addr out  ADDR_W  write address
// BEHAVIOUR
//  - Reset (rst low, async): all slot valids 0, all payload regs 0, out_* = 0, in_ready = 1.
//  - Accept when in_valid & in_ready; emit when out_valid & out_ready. Payload changes only on accept.
//  - Latency: STAGES cycles from accept to out_valid with no stall; throughput 1 beat/cycle.
//  - Slot i loads when empty or slot i+1 (or downstream) takes its beat the same cycle; full slot
//    with simultaneous pop and push passes through, no bubble.
//  - Stall: out_ready low holds out_* stable; slots fill back-to-front; in_ready drops when all full.
//  - Capacity: STAGES beats (STAGES+1 with skid); never drops or duplicates a beat.
//  - flush: priority over accept; next edge clears every valid (incl. skid); beat offered on the flush
//    cycle is discarded; payload regs may hold stale data but out_wr_en = 0 since out_valid = 0.
//  - out_valid never depends combinationally on in_valid (fully registered output).
//  - Reset mid-operation: in-flight beats lost; no beat emitted after release until new accept.
// CONFIGURATION
//  EX_MEM_SKID_EN defined: one-entry skid slot at the input; in_ready driven from a flop
//    (= skid empty); no combinational path out_ready -> in_ready; capacity STAGES+1.
//  EX_MEM_SKID_EN undefined: in_ready = ~slot0_valid | slot0_advance, combinational through the
//    ready chain from out_ready; capacity STAGES.
// STRUCTURE
//  Package mips_pipe_pkg: typedef struct ex_mem_payload_t {inst, res, wr_en, write_addr},
//    localparam EX_MEM_PAYLOAD_W, default width constants.
//  Sub-module pipe_stage_slot: one valid+payload register with load/advance/flush logic;
//    generate-loop STAGES instances; skid slot reuses pipe_stage_slot.
// TESTING
//  1 STAGES=2, out_ready=1, back-to-back inst 0x1111..0x1115 -> same values on out 2 cycles later,
//    one per cycle, in order, in_ready stays 1.
//  2 out_ready=0 for 3 cycles mid-stream -> out_inst holds 0x1111, in_ready falls after 2 (3 w/ skid)
//    accepts; on release all beats emerge in order, none lost/duplicated.
//  3 flush pulse with 2 beats in flight and in_valid=1 -> out_valid=0 next cycle; none of the 3 beats
//    ever emitted; next accepted beat 0x2222 emerges after STAGES cycles.
//  4 beat wr_en=1 addr=5 res=0xBEEF -> out_wr_en=1, out_write_addr=5, out_res=0xBEEF only while
//    out_valid; out_wr_en=0 on every idle cycle.
//  5 rst asserted low asynchronously mid-cycle with full slots -> all out_* = 0, in_ready=1
//    immediately; nothing emitted after release.
//  6 EX_MEM_SKID_EN defined: toggle out_ready with zero delay -> in_ready changes only at clk edges.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared EX->MEM payload type and default width constants
// Purpose: common definitions for the EX->MEM pipeline register and the stages around it.
// Contents:
//   EX_MEM_INST_W / EX_MEM_DATA_W / EX_MEM_ADDR_W  default field widths
//   ex_mem_payload_t                               {inst, res, wr_en, write_addr}
//   EX_MEM_PAYLOAD_W                               packed width of ex_mem_payload_t
package mips_pipe_pkg;

   localparam int EX_MEM_INST_W = 16;
   localparam int EX_MEM_DATA_W = 16;
   localparam int EX_MEM_ADDR_W = 3;

   // Field order matches the flat vector packing used inside ex_mem_pipe_stage,
   // so a default-width stage output can be cast straight to this type.
   typedef struct packed {
      logic [EX_MEM_INST_W-1:0] inst;
      logic [EX_MEM_DATA_W-1:0] res;
      logic                     wr_en;
      logic [EX_MEM_ADDR_W-1:0] write_addr;
   } ex_mem_payload_t;

   localparam int EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

endpackage

// File: rtl/pipe_stage_slot.sv
// rtl/pipe_stage_slot.sv - one valid+payload register slot with load/advance/flush
// Purpose: a single pipeline slot; it takes a new beat whenever it is empty or its
//          current beat is leaving the same cycle, so a full slot passes beats with no bubble.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 clears valid on the next edge, overriding any load
//   in_valid, in_payload  beat offered by the upstream side
//   out_valid, out_payload registered beat held by this slot
//   out_ready             downstream takes the held beat this cycle
module pipe_stage_slot
   import mips_pipe_pkg::*;
#(
   parameter int W = EX_MEM_PAYLOAD_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_payload,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_payload
);

   logic         valid_d;
   logic         valid_q;
   logic [W-1:0] payload_d;
   logic [W-1:0] payload_q;
   logic         load;

   always_comb begin
      load      = ~valid_q | out_ready;
      valid_d   = valid_q;
      payload_d = payload_q;
      if (flush) begin
         // Payload is left alone on flush; the cleared valid masks it.
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = in_valid;
         if (in_valid) begin
            payload_d = in_payload;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_payload = payload_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// rtl/ex_mem_pipe_stage.sv - parametrised EX->MEM pipeline register with handshake, stall, flush
// Purpose: carries instruction, ALU result, write enable and write address through STAGES
//          chained slots between the execute ALU and the memory stage.
// Build option: EX_MEM_SKID_EN adds a one-entry input skid slot; in_ready then comes from a
//          flop (skid empty) and capacity becomes STAGES+1. Without it in_ready is
//          combinational through the ready chain from out_ready and capacity is STAGES.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   flush                         squash every in-flight beat (and the beat offered this cycle)
//   in_valid / in_ready           upstream handshake
//   in_inst, in_res, in_wr_en, in_write_addr      upstream payload
//   out_valid / out_ready         downstream handshake
//   out_inst, out_res, out_wr_en, out_write_addr  downstream payload (out_wr_en gated by out_valid)
module ex_mem_pipe_stage
   import mips_pipe_pkg::*;
#(
   parameter int INST_W = EX_MEM_INST_W,
   parameter int DATA_W = EX_MEM_DATA_W,
   parameter int ADDR_W = EX_MEM_ADDR_W,
   parameter int STAGES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [DATA_W-1:0] in_res,
   input  logic              in_wr_en,
   input  logic [ADDR_W-1:0] in_write_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [DATA_W-1:0] out_res,
   output logic              out_wr_en,
   output logic [ADDR_W-1:0] out_write_addr
);

   localparam int PW = INST_W + DATA_W + 1 + ADDR_W;

   if (STAGES < 1) begin : g_bad_stages
      $error("ex_mem_pipe_stage: STAGES must be >= 1");
   end

   logic              head_valid;
   logic              head_ready;
   logic [PW-1:0]     head_payload;
   logic [PW-1:0]     in_payload;
   logic [STAGES-1:0] slot_valid;
   logic [STAGES-1:0] down_ready;
   logic [PW-1:0]     slot_payload [STAGES];
   logic              tail_wr_en;

   assign in_payload = {in_inst, in_res, in_wr_en, in_write_addr};

   // Slot i may hand its beat on when every slot behind it toward MEM is full and MEM
   // is taking, or any of them has a hole. Written directly from the valid flops so the
   // ready chain never feeds back on itself.
   for (genvar i = 0; i < STAGES; i++) begin : g_ready
      if (i == STAGES - 1) begin : g_last
         assign down_ready[i] = out_ready;
      end else begin : g_mid
         assign down_ready[i] = ~(&slot_valid[STAGES-1:i+1]) | out_ready;
      end
   end

   assign head_ready = ~slot_valid[0] | down_ready[0];

   for (genvar i = 0; i < STAGES; i++) begin : g_slot
      logic          src_valid;
      logic [PW-1:0] src_payload;
      if (i == 0) begin : g_head
         assign src_valid   = head_valid;
         assign src_payload = head_payload;
      end else begin : g_chain
         assign src_valid   = slot_valid[i-1];
         assign src_payload = slot_payload[i-1];
      end
      pipe_stage_slot #(.W(PW)) u_slot (
         .clk         (clk),
         .rst_n       (rst),
         .flush       (flush),
         .in_valid    (src_valid),
         .in_payload  (src_payload),
         .out_valid   (slot_valid[i]),
         .out_ready   (down_ready[i]),
         .out_payload (slot_payload[i])
      );
   end

`ifdef EX_MEM_SKID_EN
   logic          skid_valid;
   logic [PW-1:0] skid_payload;

   // The skid only captures a beat that the head slot cannot take this cycle; while it
   // holds one, it is the head's source and upstream is held off.
   pipe_stage_slot #(.W(PW)) u_skid (
      .clk         (clk),
      .rst_n       (rst),
      .flush       (flush),
      .in_valid    (in_valid & ~skid_valid & ~head_ready),
      .in_payload  (in_payload),
      .out_valid   (skid_valid),
      .out_ready   (head_ready),
      .out_payload (skid_payload)
   );

   assign in_ready     = ~skid_valid;
   assign head_valid   = skid_valid | in_valid;
   assign head_payload = skid_valid ? skid_payload : in_payload;
`else
   assign in_ready     = head_ready;
   assign head_valid   = in_valid;
   assign head_payload = in_payload;
`endif

   assign out_valid = slot_valid[STAGES-1];
   assign {out_inst, out_res, tail_wr_en, out_write_addr} = slot_payload[STAGES-1];
   assign out_wr_en = tail_wr_en & out_valid;

endmodule
